// File: rtl/ram_block_p_pkg.sv
// ram_block_p_pkg: shared types and sizing helpers for ram_block_p.
// Provides the clear-FSM state enum, reference-select width and depth helpers.
package ram_block_p_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // A single reference register still gets a 1-bit select port.
    function automatic int calc_rsel_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ram_ref_bank.sv
// ram_ref_bank: NUM_REF reference registers with indexed load, flattened output.
// Ports: clk, rst_n, i_we/i_sel/i_data (load), o_ref (slot k at [k*REF_W +: REF_W]).
module ram_ref_bank
    import ram_block_p_pkg::*;
#(
    parameter int               NUM_REF  = 2,
    parameter int               REF_W    = 16,
    parameter logic [REF_W-1:0] REF_INIT = '0,
    localparam int              RSEL_W   = calc_rsel_w(NUM_REF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [RSEL_W-1:0]        i_sel,
    input  logic [REF_W-1:0]         i_data,
    output logic [NUM_REF*REF_W-1:0] o_ref
);

    // An out-of-range select matches no slot, so the load is dropped.
    for (genvar k = 0; k < NUM_REF; k++) begin : g_slot
        logic [REF_W-1:0] r_slot;
        logic             w_hit;

        assign w_hit = i_we && (i_sel == RSEL_W'(k));

        always_ff @(negedge clk) begin
            if (!rst_n) begin
                r_slot <= REF_INIT;
            end else if (w_hit) begin
                r_slot <= i_data;
            end
        end

        assign o_ref[k*REF_W +: REF_W] = r_slot;
    end

endmodule

// File: rtl/ram_block_p.sv
// ram_block_p: simple-dual-port RAM, write-first bypass, ref bank, clear engine.
// Ports: write (Address_w/W/Data_I), read (Address/R/Data_O/rd_valid),
//        refs (W_ref/ref_sel/Ref), clear (clr_start/clr_busy/clr_done).
module ram_block_p
    import ram_block_p_pkg::*;
#(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 8,
    parameter int               REF_W    = 16,
    parameter int               NUM_REF  = 2,
    parameter logic [REF_W-1:0] REF_INIT = '0,
    localparam int              RSEL_W   = calc_rsel_w(NUM_REF)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        Address_w,
    input  logic                     W,
    input  logic [DATA_W-1:0]        Data_I,
    input  logic [ADDR_W-1:0]        Address,
    input  logic                     R,
    output logic [DATA_W-1:0]        Data_O,
    output logic                     rd_valid,
    input  logic                     W_ref,
    input  logic [RSEL_W-1:0]        ref_sel,
    output logic [NUM_REF*REF_W-1:0] Ref,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int              DEPTH = calc_depth(ADDR_W);
    localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

    clr_state_e        r_state;
    clr_state_e        w_state_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              r_rd_valid;
    logic              r_done;

    logic w_last;
    logic w_mem_we;
    logic w_clr_we;
    logic w_rd_en;
    logic w_bypass;

    assign w_last = (r_cnt == LAST);

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (clr_start) w_state_nxt = CLEAR;
            CLEAR: if (w_last)    w_state_nxt = IDLE;
        endcase
    end

    // Host ports are only live in IDLE; CLEAR owns the write port.
    always_comb begin
        w_mem_we = 1'b0;
        w_clr_we = 1'b0;
        w_rd_en  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_mem_we = W;
                w_rd_en  = R;
            end
            CLEAR: w_clr_we = 1'b1;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + (ADDR_W+1)'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // No writes under reset, so an aborted clear leaves untouched words intact.
    always_ff @(negedge clk) begin
        if (rst_n) begin
            if (w_clr_we) begin
                r_mem[r_cnt[ADDR_W-1:0]] <= '0;
            end else if (w_mem_we) begin
                r_mem[Address_w] <= Data_I;
            end
        end
    end

    // Write-first: a same-address write is forwarded to the read data.
    assign w_bypass = w_mem_we && (Address == Address_w);

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            if (w_rd_en) begin
                r_dout <= w_bypass ? Data_I : r_mem[Address];
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == CLEAR) && w_last;
        end
    end

    assign Data_O   = r_dout;
    assign rd_valid = r_rd_valid;
    assign clr_busy = (r_state == CLEAR);
    assign clr_done = r_done;

    ram_ref_bank #(
        .NUM_REF  (NUM_REF),
        .REF_W    (REF_W),
        .REF_INIT (REF_INIT)
    ) u_ref_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (W_ref),
        .i_sel  (ref_sel),
        .i_data (Data_I[REF_W-1:0]),
        .o_ref  (Ref)
    );

endmodule

// File: tb/tb_ram_block_p.sv
// tb_ram_block_p: self-checking bench for ram_block_p (default parameters).
// Drives just after each falling edge, checks outputs against a behavioural model.
module tb_ram_block_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  Address_w;
    logic        W;
    logic [31:0] Data_I;
    logic [7:0]  Address;
    logic        R;
    logic [31:0] Data_O;
    logic        rd_valid;
    logic        W_ref;
    logic        ref_sel;
    logic [31:0] Ref;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [256];
    logic [15:0] ref_m [2];
    logic [31:0] exp_do;

    ram_block_p dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Address_w (Address_w),
        .W         (W),
        .Data_I    (Data_I),
        .Address   (Address),
        .R         (R),
        .Data_O    (Data_O),
        .rd_valid  (rd_valid),
        .W_ref     (W_ref),
        .ref_sel   (ref_sel),
        .Ref       (Ref),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        W = 0; R = 0; W_ref = 0; clr_start = 0;
        Address_w = '0; Address = '0; Data_I = '0; ref_sel = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        W = 1; Address_w = a; Data_I = d;
        step();
        W = 0;
        mem_m[a] = d;
    endtask

    task automatic rd(input logic [7:0] a);
        R = 1; Address = a;
        step();
        R = 0;
        exp_do = mem_m[a];
    endtask

    task automatic test_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        ref_m[0] = 16'h0;
        ref_m[1] = 16'h0;
        exp_do = 32'h0;
        checks++;
        if (Data_O !== 32'h0) begin
            errors++; $display("FAIL reset_dout got=%h exp=0", Data_O);
        end
        checks++;
        if ({rd_valid, clr_busy, clr_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000", {rd_valid, clr_busy, clr_done});
        end
        checks++;
        if (Ref !== {ref_m[1], ref_m[0]}) begin
            errors++; $display("FAIL reset_ref got=%h exp=%h", Ref, {ref_m[1], ref_m[0]});
        end
    endtask

    task automatic test_write_read();
        wr(8'h05, 32'hDEADBEEF);
        rd(8'h05);
        checks++;
        if (Data_O !== 32'hDEADBEEF || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd got=%h/%b exp=deadbeef/1", Data_O, rd_valid);
        end
        step();
        checks++;
        if (Data_O !== 32'hDEADBEEF || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_hold got=%h/%b exp=deadbeef/0", Data_O, rd_valid);
        end
        checks++;
        if (Ref !== 32'h0) begin
            errors++; $display("FAIL wr_rd_ref got=%h exp=0", Ref);
        end
    endtask

    task automatic test_collision();
        wr(8'h10, 32'h1);
        W = 1; Address_w = 8'h10; Data_I = 32'h2;
        R = 1; Address = 8'h10;
        step();
        W = 0; R = 0;
        mem_m[8'h10] = 32'h2;
        checks++;
        if (Data_O !== 32'h2 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL collision got=%h/%b exp=2/1", Data_O, rd_valid);
        end
        rd(8'h10);
        checks++;
        if (Data_O !== 32'h2) begin
            errors++; $display("FAIL collision_mem got=%h exp=2", Data_O);
        end
    endtask

    task automatic test_ref_bank();
        W_ref = 1; ref_sel = 0; Data_I = 32'h12341111;
        step();
        ref_m[0] = 16'h1111;
        checks++;
        if (Ref !== 32'h00001111) begin
            errors++; $display("FAIL ref_slot0 got=%h exp=00001111", Ref);
        end
        ref_sel = 1; Data_I = 32'h2222;
        step();
        ref_m[1] = 16'h2222;
        checks++;
        if (Ref !== 32'h22221111) begin
            errors++; $display("FAIL ref_slot1 got=%h exp=22221111", Ref);
        end
        for (int i = 0; i < 24; i++) begin
            W_ref = 1'($urandom_range(0, 1));
            ref_sel = 1'($urandom_range(0, 1));
            Data_I = $urandom;
            W = 1'($urandom_range(0, 1));
            Address_w = 8'h40;
            step();
            if (W) mem_m[8'h40] = Data_I;
            if (W_ref) ref_m[ref_sel] = Data_I[15:0];
            checks++;
            if (Ref !== {ref_m[1], ref_m[0]}) begin
                errors++;
                $display("FAIL ref_rand got=%h exp=%h", Ref, {ref_m[1], ref_m[0]});
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_cnt;
        for (int a = 0; a < 256; a++) wr(8'(a), 32'hA5A5A5A5);
        clr_start = 1;
        step();
        clr_start = 0;
        busy_cnt = clr_busy ? 1 : 0;
        done_cnt = clr_done ? 1 : 0;
        for (int i = 0; i < 259; i++) begin
            step();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        for (int a = 0; a < 256; a++) mem_m[a] = 32'h0;
        checks++;
        if (busy_cnt != 256) begin
            errors++; $display("FAIL clear_busy_len got=%0d exp=256", busy_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL clear_done_cnt got=%0d exp=1", done_cnt);
        end
        for (int a = 0; a < 256; a++) begin
            rd(8'(a));
            checks++;
            if (Data_O !== exp_do) begin
                errors++;
                $display("FAIL clear_read addr=%0d got=%h exp=%h", a, Data_O, exp_do);
            end
        end
    endtask

    task automatic test_random_rw();
        logic        w_b, r_b;
        logic [7:0]  aw, ar;
        logic [31:0] d;
        for (int i = 0; i < 200; i++) begin
            w_b = 1'($urandom_range(0, 1));
            r_b = 1'($urandom_range(0, 1));
            aw  = 8'($urandom_range(0, 15));
            ar  = 8'($urandom_range(0, 15));
            d   = $urandom;
            W = w_b; R = r_b; Address_w = aw; Address = ar; Data_I = d;
            step();
            if (r_b) exp_do = (w_b && aw == ar) ? d : mem_m[ar];
            if (w_b) mem_m[aw] = d;
            checks++;
            if (rd_valid !== r_b) begin
                errors++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, rd_valid, r_b);
            end
            checks++;
            if (Data_O !== exp_do) begin
                errors++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, Data_O, exp_do);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear_interference();
        int busy_cnt;
        int done_cnt;
        wr(8'h30, 32'h55);
        rd(8'h30);
        checks++;
        if (Data_O !== 32'h55) begin
            errors++; $display("FAIL intf_pre got=%h exp=55", Data_O);
        end
        clr_start = 1;
        step();
        clr_start = 0;
        busy_cnt = clr_busy ? 1 : 0;
        done_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            idle_inputs();
            if (i == 10) begin
                W = 1; Address_w = 8'h20; Data_I = 32'h77; R = 1; Address = 8'h30;
            end
            if (i == 11) begin
                W_ref = 1; ref_sel = 1; Data_I = 32'h0000BEEF; R = 1; Address = 8'h20;
            end
            if (i == 12) clr_start = 1;
            step();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (i == 10 || i == 11) begin
                checks++;
                if (rd_valid !== 1'b0 || Data_O !== exp_do) begin
                    errors++;
                    $display("FAIL intf_read i=%0d got=%h/%b exp=%h/0", i, Data_O, rd_valid, exp_do);
                end
            end
            if (i == 11) begin
                ref_m[1] = 16'hBEEF;
                checks++;
                if (Ref[31:16] !== 16'hBEEF) begin
                    errors++; $display("FAIL intf_ref got=%h exp=beef", Ref[31:16]);
                end
            end
            if (!clr_busy) break;
        end
        idle_inputs();
        for (int a = 0; a < 256; a++) mem_m[a] = 32'h0;
        checks++;
        if (busy_cnt != 256 || done_cnt != 1) begin
            errors++;
            $display("FAIL intf_len got=%0d/%0d exp=256/1", busy_cnt, done_cnt);
        end
        step();
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL intf_restart got=%b%b exp=00", clr_busy, clr_done);
        end
        rd(8'h20);
        checks++;
        if (Data_O !== 32'h0) begin
            errors++; $display("FAIL intf_w_ignored got=%h exp=0", Data_O);
        end
        rd(8'h30);
        checks++;
        if (Data_O !== 32'h0) begin
            errors++; $display("FAIL intf_cleared got=%h exp=0", Data_O);
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_cnt;
        for (int a = 0; a < 256; a++) wr(8'(a), 32'hA5A5A5A5);
        clr_start = 1;
        step();
        clr_start = 0;
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (clr_done) done_cnt++;
        end
        checks++;
        if (clr_busy !== 1'b1 || done_cnt != 0) begin
            errors++;
            $display("FAIL midclr_pre got=%b/%0d exp=1/0", clr_busy, done_cnt);
        end
        rst_n = 0;
        step();
        rst_n = 1;
        for (int a = 0; a < 100; a++) mem_m[a] = 32'h0;
        ref_m[0] = 16'h0;
        ref_m[1] = 16'h0;
        exp_do = 32'h0;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0 || Data_O !== exp_do) begin
            errors++;
            $display("FAIL midclr_rst got=%b%b/%h exp=00/0", clr_busy, clr_done, Data_O);
        end
        checks++;
        if (Ref !== {ref_m[1], ref_m[0]}) begin
            errors++; $display("FAIL midclr_ref got=%h exp=0", Ref);
        end
        step();
        checks++;
        if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin
            errors++; $display("FAIL midclr_nodone got=%b%b exp=00", clr_busy, clr_done);
        end
        for (int a = 0; a < 256; a++) begin
            rd(8'(a));
            checks++;
            if (Data_O !== exp_do) begin
                errors++;
                $display("FAIL midclr_read addr=%0d got=%h exp=%h", a, Data_O, exp_do);
            end
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_collision();
        test_ref_bank();
        test_clear();
        test_random_rw();
        test_clear_interference();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
